ifconv_rnd_pipe: RTL and testbench
==================================

// Module: ifconv_rnd_pipe
// PURPOSE
//  Parametrised integer-to-float converter for the FP math unit, with full IEEE rounding.
//  Takes a signed or unsigned IW-bit integer and produces a single, double or extended result.
//  Adds five rounding modes, an inexact flag, a valid pipeline and a stall, so the FP issue port can stream it.
//  Fixed 3-stage pipeline, one result per enabled cycle.
// PARAMETERS
//  IW    64  integer operand width, legal 16..64
// PORTS
//  clk     in   1   clock, all state on posedge
//  rst     in   1   asynchronous, active-low reset
//  clkEn   in   1   pipeline advance; 0 = every stage holds (stall)
//  in_vld  in   1   operand valid this cycle
//  A       in   IW  integer operand
//  isS     in   1   1 = A is two's complement, 0 = unsigned
//  toSNG   in   1   target single (one-hot with toDBL/toEXT)
//  toDBL   in   1   target double
//  toEXT   in   1   target 80-bit extended
//  rm      in   3   0 RNE, 1 RTZ, 2 RDN(-inf), 3 RUP(+inf), 4 RMM; 5-7 act as RNE
//  out_vld out  1   res/rtyp/inexact valid
//  res     out  82  SNG: IEEE single in [31:0]; DBL: IEEE double in [63:0];
//                   EXT: x87 80-bit (explicit J bit) in [79:0]; unused upper bits 0
//  rtyp    out  2   `ptype_sngl / `ptype_dbl / `ptype_ext
//  inexact out  1   rounding discarded nonzero bits
// BEHAVIOUR
//  Reset (rst=0, async): all valid bits, res, rtyp and inexact go to 0 immediately.
//   In-flight ops are dropped; the first op accepted after rst rises returns 3 enabled cycles later.
//  Stall: clkEn=0 freezes every register, including the valids. in_vld is ignored while clkEn=0.
//  Latency: an op accepted at enabled edge N appears at enabled edge N+2 (out_vld=1 after 3 clkEn edges incl. capture).
//   out_vld=0 otherwise; res holds its last value when out_vld=0.
//  S1: sign = isS & A[IW-1]; mag = sign ? -A : A, taken as an unsigned IW-bit value (-2^(IW-1) maps to 2^(IW-1), exact).
//   Register sign, mag, target and rm.
//  S2: leading-one detect on mag gives lz. norm = mag << lz (MSB=1). exp_unb = IW-1-lz.
//   zero flag when mag=0.
//  S3: fraction width F = 23/52/63, significand P = F+1.
//   G = norm bit below the kept P bits; S = OR of the remaining bits.
//   Round up when: RNE G&(S|L); RTZ never; RDN sign&(G|S); RUP ~sign&(G|S); RMM G.
//   Carry out of the significand: significand <- 1.000..., exp+1.
//   Biased exp = exp_unb + 127/1023/16383 (+carry); no overflow is possible for IW<=64.
//  inexact = G|S. EXT with IW<=64 is always exact.
//  Zero: result +0.0 (exp 0, frac 0, sign 0), inexact=0, in all modes.
//  Target select: priority EXT > DBL > SNG if more than one is set.
//   None set: res=0, rtyp=`ptype_dbl, inexact=0, out_vld still follows in_vld.
//  Inputs are only sampled on enabled edges with in_vld=1.
//   Stages with valid=0 still clock data, but that data must never raise out_vld.
// TESTING
//  A=1, isS=0, toSNG, RNE -> 3 edges later out_vld=1, res=0x3F800000, rtyp=`ptype_sngl, inexact=0.
//  A=64'hFFFF_FFFF_FFFF_FFFF, isS=1, toDBL -> res=0xBFF0000000000000, exact.
//   Same A with isS=0, RNE -> 0x43F0000000000000, inexact=1.
//  A=64'h7FFF_FFFF_FFFF_FFFF, isS=0, toSNG: RNE -> 0x5F000000, RTZ -> 0x5EFFFFFF, RUP -> 0x5F000000; all inexact=1.
//  A=64'h8000_0000_0000_0000, isS=1, toEXT -> res[79:0]=0xC03E_8000000000000000, inexact=0.
//   Same A with RDN and toSNG -> 0xDF000000, exact.
//  Stream 4 back-to-back ops with clkEn=0 for 2 cycles mid-stream.
//   Results emerge in order, none lost or duplicated, out_vld frozen during the stall.
//  Assert rst=0 with 2 ops in flight -> outputs 0 asynchronously.
//   After release, no stale out_vld appears; a new op returns after 3 edges.

Source files
------------

// File: rtl/ifconv_rnd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ifconv_rnd_pipe
//  Description : Three-stage integer-to-float converter producing single,
//                double or x87 extended results with IEEE rounding, inexact
//                flag, valid pipeline and whole-pipe stall.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef PTYPE_SNGL
`define PTYPE_SNGL 2'd0
`endif
`ifndef PTYPE_DBL
`define PTYPE_DBL  2'd1
`endif
`ifndef PTYPE_EXT
`define PTYPE_EXT  2'd2
`endif

module ifconv_rnd_pipe #(
    parameter int IW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clkEn,
    input  logic          in_vld,
    input  logic [IW-1:0] A,
    input  logic          isS,
    input  logic          toSNG,
    input  logic          toDBL,
    input  logic          toEXT,
    input  logic [2:0]    rm,
    output logic          out_vld,
    output logic [81:0]   res,
    output logic [1:0]    rtyp,
    output logic          inexact
);

    localparam int LZW = $clog2(IW);
    // Normalised operand padded so the extended format still has G and S bits.
    localparam int NXW = 66;

    localparam logic [1:0] C_TG_NONE = 2'd0;
    localparam logic [1:0] C_TG_SNG  = 2'd1;
    localparam logic [1:0] C_TG_DBL  = 2'd2;
    localparam logic [1:0] C_TG_EXT  = 2'd3;

    // Round-up decision for one format given guard, sticky and kept LSB.
    function automatic logic rnd_up(input logic [2:0] m, input logic sg,
                                    input logic g, input logic s, input logic l);
        case (m)
            3'd1:    rnd_up = 1'b0;
            3'd2:    rnd_up = sg & (g | s);
            3'd3:    rnd_up = ~sg & (g | s);
            3'd4:    rnd_up = g;
            default: rnd_up = g & (s | l);
        endcase
    endfunction

    // ---------------- Stage 1: sign / magnitude ----------------
    logic          s1_sign_d, s1_sign_q;
    logic [IW-1:0] s1_mag_d,  s1_mag_q;
    logic [1:0]    s1_tgt_d,  s1_tgt_q;
    logic [2:0]    s1_rm_q;
    logic          s1_vld_q;

    // Magnitude of the operand and target decode (EXT wins, then DBL, then SNG).
    always_comb begin
        s1_sign_d = isS & A[IW-1];
        s1_mag_d  = s1_sign_d ? -A : A;
        if (toEXT)      s1_tgt_d = C_TG_EXT;
        else if (toDBL) s1_tgt_d = C_TG_DBL;
        else if (toSNG) s1_tgt_d = C_TG_SNG;
        else            s1_tgt_d = C_TG_NONE;
    end

    // Capture stage: operand data is only sampled for valid ops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= '0;
            s1_tgt_q  <= C_TG_NONE;
            s1_rm_q   <= 3'd0;
        end else if (clkEn) begin
            s1_vld_q <= in_vld;
            if (in_vld) begin
                s1_sign_q <= s1_sign_d;
                s1_mag_q  <= s1_mag_d;
                s1_tgt_q  <= s1_tgt_d;
                s1_rm_q   <= rm;
            end
        end
    end

    // ---------------- Stage 2: normalise ----------------
    logic [LZW-1:0] lz_d;
    logic [IW-1:0]  s2_norm_d, s2_norm_q;
    logic [6:0]     s2_exp_d,  s2_exp_q;
    logic           s2_zero_d, s2_zero_q;
    logic           s2_sign_q, s2_vld_q;
    logic [1:0]     s2_tgt_q;
    logic [2:0]     s2_rm_q;

    // Leading-one detect; the highest set bit overwrites lower ones.
    always_comb begin
        lz_d = '0;
        for (int i = 0; i < IW; i++) begin
            if (s1_mag_q[i]) lz_d = LZW'(IW - 1 - i);
        end
        s2_norm_d = s1_mag_q << lz_d;
        s2_exp_d  = 7'(IW - 1) - {{(7-LZW){1'b0}}, lz_d};
        s2_zero_d = ~|s1_mag_q;
    end

    // Normalise stage register; data flows regardless of valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld_q  <= 1'b0;
            s2_norm_q <= '0;
            s2_exp_q  <= 7'd0;
            s2_zero_q <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_tgt_q  <= C_TG_NONE;
            s2_rm_q   <= 3'd0;
        end else if (clkEn) begin
            s2_vld_q  <= s1_vld_q;
            s2_norm_q <= s2_norm_d;
            s2_exp_q  <= s2_exp_d;
            s2_zero_q <= s2_zero_d;
            s2_sign_q <= s1_sign_q;
            s2_tgt_q  <= s1_tgt_q;
            s2_rm_q   <= s1_rm_q;
        end
    end

    // ---------------- Stage 3: round and pack ----------------
    logic [NXW-1:0] nx;
    logic           up_s, up_d, up_e;
    logic [23:0]    sng_fr;
    logic [52:0]    dbl_fr;
    logic [64:0]    ext_sg;
    logic [7:0]     sng_exp;
    logic [10:0]    dbl_exp;
    logic [14:0]    ext_exp;
    logic [63:0]    ext_mant;
    logic [81:0]    res_d,  res_q;
    logic [1:0]     rtyp_d, rtyp_q;
    logic           inx_d,  inx_q;
    logic           vld_q;

    // Round each format from the padded normalised value and select by target.
    always_comb begin
        nx   = {s2_norm_q, {(NXW-IW){1'b0}}};
        up_s = rnd_up(s2_rm_q, s2_sign_q, nx[41], |nx[40:0], nx[42]);
        up_d = rnd_up(s2_rm_q, s2_sign_q, nx[12], |nx[11:0], nx[13]);
        up_e = rnd_up(s2_rm_q, s2_sign_q, nx[1],  nx[0],     nx[2]);

        // Fraction-only increment: a carry out means 10.000... -> exp+1, frac 0.
        sng_fr  = {1'b0, nx[64:42]} + {23'd0, up_s};
        dbl_fr  = {1'b0, nx[64:13]} + {52'd0, up_d};
        ext_sg  = {1'b0, nx[65:2]}  + {64'd0, up_e};
        sng_exp = {1'b0, s2_exp_q} + 8'd127 + {7'd0, sng_fr[23]};
        dbl_exp = {4'd0, s2_exp_q} + 11'd1023 + {10'd0, dbl_fr[52]};
        ext_exp = {8'd0, s2_exp_q} + 15'd16383 + {14'd0, ext_sg[64]};
        ext_mant = ext_sg[64] ? {1'b1, 63'd0} : ext_sg[63:0];

        res_d  = '0;
        rtyp_d = `PTYPE_DBL;
        inx_d  = 1'b0;
        case (s2_tgt_q)
            C_TG_SNG: begin
                rtyp_d = `PTYPE_SNGL;
                res_d  = {50'd0, s2_sign_q, sng_exp, sng_fr[22:0]};
                inx_d  = nx[41] | (|nx[40:0]);
            end
            C_TG_DBL: begin
                rtyp_d = `PTYPE_DBL;
                res_d  = {18'd0, s2_sign_q, dbl_exp, dbl_fr[51:0]};
                inx_d  = nx[12] | (|nx[11:0]);
            end
            C_TG_EXT: begin
                rtyp_d = `PTYPE_EXT;
                res_d  = {2'd0, s2_sign_q, ext_exp, ext_mant};
                inx_d  = nx[1] | nx[0];
            end
            default: begin
                rtyp_d = `PTYPE_DBL;
                res_d  = '0;
                inx_d  = 1'b0;
            end
        endcase
        // A zero operand always yields +0.0, exact, whatever the rounding mode.
        if (s2_zero_q) begin
            res_d = '0;
            inx_d = 1'b0;
        end
    end

    // Output stage: results only update for valid ops and hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            res_q  <= '0;
            rtyp_q <= 2'd0;
            inx_q  <= 1'b0;
        end else if (clkEn) begin
            vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                res_q  <= res_d;
                rtyp_q <= rtyp_d;
                inx_q  <= inx_d;
            end
        end
    end

    assign out_vld = vld_q;
    assign res     = res_q;
    assign rtyp    = rtyp_q;
    assign inexact = inx_q;

endmodule

`default_nettype wire

// File: tb/tb_ifconv_rnd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifconv_rnd_pipe
//  Description : Self-checking bench for ifconv_rnd_pipe: vector table
//                streamed through a scoreboard, plus stall and reset
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef PTYPE_SNGL
`define PTYPE_SNGL 2'd0
`endif
`ifndef PTYPE_DBL
`define PTYPE_DBL  2'd1
`endif
`ifndef PTYPE_EXT
`define PTYPE_EXT  2'd2
`endif

module tb_ifconv_rnd_pipe;

    localparam int IW = 64;

    typedef struct {
        logic [63:0] a;
        logic        iss;
        logic [2:0]  tg;     // {ext, dbl, sng}
        logic [2:0]  rm;
        logic [81:0] res;
        logic [1:0]  rtyp;
        logic        inx;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clkEn;
    logic          in_vld;
    logic [IW-1:0] A;
    logic          isS, toSNG, toDBL, toEXT;
    logic [2:0]    rm;
    logic          out_vld;
    logic [81:0]   res;
    logic [1:0]    rtyp;
    logic          inexact;

    int   checks   = 0;
    int   failures = 0;
    vec_t cur_exp;
    vec_t sb[$];
    vec_t vt[20];
    logic [2:0] pv = 3'b000;

    ifconv_rnd_pipe #(.IW(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .clkEn   (clkEn),
        .in_vld  (in_vld),
        .A       (A),
        .isS     (isS),
        .toSNG   (toSNG),
        .toDBL   (toDBL),
        .toEXT   (toEXT),
        .rm      (rm),
        .out_vld (out_vld),
        .res     (res),
        .rtyp    (rtyp),
        .inexact (inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [81:0] got, input logic [81:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        A       = v.a;
        isS     = v.iss;
        toSNG   = v.tg[0];
        toDBL   = v.tg[1];
        toEXT   = v.tg[2];
        rm      = v.rm;
        in_vld  = 1'b1;
        clkEn   = 1'b1;
        cur_exp = v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_vld = 1'b0;
            clkEn  = 1'b1;
            A      = {$urandom, $urandom};
            @(negedge clk);
        end
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            in_vld = 1'b1;           // must be ignored while stalled
            clkEn  = 1'b0;
            A      = {$urandom, $urandom};
            @(negedge clk);
        end
    endtask

    // Scoreboard: timing model of the valid pipe, push on accept, pop on output.
    initial begin
        vec_t e;
        logic adv;
        forever begin
            @(posedge clk);
            adv = rst && clkEn;
            if (!rst) begin
                pv = 3'b000;
                sb.delete();
            end else if (adv) begin
                pv = {pv[1:0], in_vld};
                if (in_vld) sb.push_back(cur_exp);
            end
            #1;
            chk("out_vld", {81'd0, out_vld}, {81'd0, pv[2]});
            if (adv && pv[2]) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty got=out_vld required=queued_op");
                end else begin
                    e = sb.pop_front();
                    chk("res", res, e.res);
                    chk("rtyp", {80'd0, rtyp}, {80'd0, e.rtyp});
                    chk("inexact", {81'd0, inexact}, {81'd0, e.inx});
                end
            end
        end
    end

    initial begin
        vt[0]  = '{64'h1, 1'b0, 3'b001, 3'd0, 82'h3F800000, `PTYPE_SNGL, 1'b0};
        vt[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'b010, 3'd0, 82'hBFF0000000000000, `PTYPE_DBL, 1'b0};
        vt[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b010, 3'd0, 82'h43F0000000000000, `PTYPE_DBL, 1'b1};
        vt[3]  = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001, 3'd0, 82'h5F000000, `PTYPE_SNGL, 1'b1};
        vt[4]  = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001, 3'd1, 82'h5EFFFFFF, `PTYPE_SNGL, 1'b1};
        vt[5]  = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001, 3'd3, 82'h5F000000, `PTYPE_SNGL, 1'b1};
        vt[6]  = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001, 3'd2, 82'h5EFFFFFF, `PTYPE_SNGL, 1'b1};
        vt[7]  = '{64'h8000_0000_0000_0000, 1'b1, 3'b100, 3'd0, 82'hC03E_8000000000000000, `PTYPE_EXT, 1'b0};
        vt[8]  = '{64'h8000_0000_0000_0000, 1'b1, 3'b001, 3'd2, 82'hDF000000, `PTYPE_SNGL, 1'b0};
        vt[9]  = '{64'h0, 1'b1, 3'b001, 3'd3, 82'h0, `PTYPE_SNGL, 1'b0};
        vt[10] = '{64'h5, 1'b0, 3'b000, 3'd0, 82'h0, `PTYPE_DBL, 1'b0};
        vt[11] = '{64'h1, 1'b0, 3'b111, 3'd0, 82'h3FFF_8000000000000000, `PTYPE_EXT, 1'b0};
        vt[12] = '{64'h3, 1'b0, 3'b011, 3'd0, 82'h4008000000000000, `PTYPE_DBL, 1'b0};
        vt[13] = '{64'h1000001, 1'b0, 3'b001, 3'd0, 82'h4B800000, `PTYPE_SNGL, 1'b1};
        vt[14] = '{64'h1000001, 1'b0, 3'b001, 3'd4, 82'h4B800001, `PTYPE_SNGL, 1'b1};
        vt[15] = '{64'h1000003, 1'b0, 3'b001, 3'd0, 82'h4B800002, `PTYPE_SNGL, 1'b1};
        vt[16] = '{64'hFFFF_FFFF_FEFF_FFFF, 1'b1, 3'b001, 3'd2, 82'hCB800001, `PTYPE_SNGL, 1'b1};
        vt[17] = '{64'hFFFF_FFFF_FEFF_FFFF, 1'b1, 3'b001, 3'd3, 82'hCB800000, `PTYPE_SNGL, 1'b1};
        vt[18] = '{64'h1000003, 1'b0, 3'b001, 3'd7, 82'h4B800002, `PTYPE_SNGL, 1'b1};
        vt[19] = '{64'h8000_0000_0000_0000, 1'b0, 3'b010, 3'd1, 82'h43E0000000000000, `PTYPE_DBL, 1'b0};

        rst = 1'b0; clkEn = 1'b0; in_vld = 1'b0; A = '0;
        isS = 1'b0; toSNG = 1'b0; toDBL = 1'b0; toEXT = 1'b0; rm = 3'd0;
        cur_exp = vt[0];
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_vld", {81'd0, out_vld}, 82'd0);
        chk("rst_res", res, 82'd0);
        chk("rst_rtyp", {80'd0, rtyp}, 82'd0);
        chk("rst_inexact", {81'd0, inexact}, 82'd0);
        rst = 1'b1;
        idle(2);

        // Table vectors streamed back-to-back.
        for (int i = 0; i < 20; i++) drive(vt[i]);
        idle(4);

        // Four ops with a two-cycle stall in the middle.
        drive(vt[3]);
        drive(vt[7]);
        stall(2);
        drive(vt[15]);
        drive(vt[1]);
        idle(4);

        // Asynchronous reset with two ops in flight.
        drive(vt[2]);
        drive(vt[16]);
        in_vld = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_out_vld", {81'd0, out_vld}, 82'd0);
        chk("arst_res", res, 82'd0);
        chk("arst_rtyp", {80'd0, rtyp}, 82'd0);
        chk("arst_inexact", {81'd0, inexact}, 82'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        drive(vt[12]);
        idle(5);

        chk("sb_drained", 82'(sb.size()), 82'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
